player_input_conditioner: RTL
=============================

# player_input_conditioner

Conditions one player's raw board buttons into the per-frame `player_buttons` vector that the player next-state logic consumes. Raw inputs are synchronized, debounced, converted from left/right to forward/backward for the player's side, and captured into a stable vector once per frame tick. Short taps of kick, block and grab are latched so a press between frame ticks is never lost. One instance sits between the board pins and each player's state calculator.

## Interface
- `INPUT_DEPTH`, 5, button vector width. Bit indices are `K_BUTTON`, `B_BUTTON`, `G_BUTTON`, `WB_BUTTON`, `WF_BUTTON` from params.vh.
- `DEBOUNCE_CYCLES`, 250000, number of consecutive stable sys_clk cycles required to accept a level change (5 ms at 50 MHz). Must be ≥ 2.
- `CNT_WIDTH`, 18, debounce counter width. Must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES-1.
- `FACES_LEFT`, 0, 1 swaps the forward/backward mapping (player on the right side).

Ports:
- `sys_clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `raw_buttons` in INPUT_DEPTH: active-low board keys, asynchronous. The `WF_BUTTON` bit is the physical RIGHT key and the `WB_BUTTON` bit is the physical LEFT key.
- `frame_tick` in 1: one-cycle pulse per video frame, synchronous to sys_clk.
- `player_buttons` out INPUT_DEPTH: active-high conditioned buttons, constant between ticks.
- `buttons_valid` out 1: one-cycle pulse when `player_buttons` has just updated.
- `debounced` out INPUT_DEPTH: active-high debounced levels, before direction mapping. Used for debug LEDs.

## Operation
- **Synchronizer:** two flops per bit. Sync flops reset to 1, which is the released state. After synchronization each bit is inverted to active-high `s[i]`.
- **Debounce:** each bit has its own counter `cnt[i]` and stable level `stab[i]`.
  - If `s[i]==stab[i]`, then `cnt[i]<=0`.
  - Else if `cnt[i]==DEBOUNCE_CYCLES-1`, then `stab[i]<=s[i]` and `cnt[i]<=0`.
  - Else `cnt[i]<=cnt[i]+1`.
  - Any bounce back to `stab[i]` restarts the count from 0.
  - `debounced = stab`.
- **Direction map:** raw right/left become forward/backward.
  - With `FACES_LEFT=0`: `fwd=stab[WF_BUTTON]`, `bwd=stab[WB_BUTTON]`.
  - With `FACES_LEFT=1` the two are swapped.
  - If both are 1, both are forced to 0 (a conflict produces no walk).
- **Sticky latch:** `seen[i]` applies only to `K_BUTTON`, `B_BUTTON` and `G_BUTTON`. It is set on any cycle where `stab[i]==1`.
- **Frame capture:** on the cycle where `frame_tick==1`:
  - `player_buttons[K,B,G] <= seen | stab`, using the current cycle's `stab`.
  - `player_buttons[WF] <= fwd` and `player_buttons[WB] <= bwd`. Walk bits are level-sampled only, never sticky.
  - `seen <= 0`. The clear takes priority over a same-cycle set, and that press is already carried in the captured value.
  - `buttons_valid <= 1`.
- **Between ticks:** `buttons_valid <= 0` and `player_buttons` holds.
- **Reset values:** all of the following are 0 while `rst_n` is low:
  - `player_buttons`, `buttons_valid`, `debounced`, `stab`, `cnt`, `seen`.
- **Mid-operation reset:** asserting `rst_n` low mid-count or mid-frame discards all pending state. After release, the first tick outputs only presses that are debounced after the release.

## Timing
- **Press latency:** raw edge to `stab` change is exactly 2 + DEBOUNCE_CYCLES sys_clk edges, provided the input is clean.
- **Release latency:** the same 2 + DEBOUNCE_CYCLES edges apply to a release.
- **Capture:** `player_buttons` and `buttons_valid` change on the edge that samples `frame_tick` high. `buttons_valid` is high for exactly the following cycle.
- **Stability:** `player_buttons` is stable for the full frame and is safe for the frame-rate consumer.
- **Back-to-back ticks:** `frame_tick` on consecutive cycles is legal. Each tick captures and pulses `buttons_valid`, so `buttons_valid` stays high.
- **Latch window:** a sticky button pressed and released within one frame appears in the next tick's vector only, and is cleared in the following one.
- **Counter width:** `cnt` never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES=4` and `frame_tick` every 20 cycles.
1. **Reset:** reset with all keys released → all outputs 0. First tick → `player_buttons=0` and `buttons_valid` pulses for 1 cycle.
2. **Debounced press:** hold raw K low from cycle 0 → `debounced[K]` rises on edge 6. Next tick → `player_buttons[K]=1`.
3. **Bounce rejection:** toggle raw G every 3 cycles for 30 cycles → `debounced[G]` never changes and `player_buttons[G]` stays 0.
4. **Short tap latch:** stable B pulse of 8 cycles placed between ticks → `player_buttons[B]=1` for exactly one frame, then 0.
5. **Walk mapping:** hold RIGHT only → `WF=1` with `FACES_LEFT=0` and `WB=1` with `FACES_LEFT=1`. Hold LEFT and RIGHT together → `WF=WB=0`.
6. **Simultaneous events:** `stab[K]` first goes 1 on the same cycle as `frame_tick` → this tick outputs K=1, and `seen` is cleared. Also assert `rst_n` low mid-debounce → `cnt` and `stab` return to 0, and the press needs a full 4 cycles of stability again after release.

Source files
------------

// File: rtl/player_input_conditioner_if.sv
// ---------------------------------------------------------------------------
// player_input_conditioner_if
//
// Groups the board-side and frame-side signals of one player's input
// conditioner.
//
//   raw_buttons    : active-low board keys, asynchronous to sys_clk
//   frame_tick     : one-cycle pulse per video frame, sys_clk domain
//   player_buttons : active-high conditioned vector, constant between ticks
//   buttons_valid  : one-cycle pulse, player_buttons has just updated
//   debounced      : active-high debounced levels before direction mapping
//
// Handshake: buttons_valid is a push-only qualifier with no ready. The
// consumer must take player_buttons in the cycle buttons_valid is high, or
// at any time before the next pulse, since the vector holds until then.
//
// Modports:
//   master : drives keys and ticks, observes the conditioned outputs
//   slave  : the conditioner itself
// ---------------------------------------------------------------------------
interface player_input_conditioner_if #(
    parameter int INPUT_DEPTH = 5
);
    logic [INPUT_DEPTH-1:0] raw_buttons;
    logic                   frame_tick;
    logic [INPUT_DEPTH-1:0] player_buttons;
    logic                   buttons_valid;
    logic [INPUT_DEPTH-1:0] debounced;

    modport master (
        output raw_buttons,
        output frame_tick,
        input  player_buttons,
        input  buttons_valid,
        input  debounced
    );

    modport slave (
        input  raw_buttons,
        input  frame_tick,
        output player_buttons,
        output buttons_valid,
        output debounced
    );
endinterface

// File: rtl/player_input_conditioner.sv
// ---------------------------------------------------------------------------
// player_input_conditioner
//
// Turns one player's raw board keys into the per-frame player_buttons vector:
// two-flop synchronizer, per-bit debounce, left/right to forward/backward
// mapping, sticky latching of kick/block/grab taps, and capture on frame_tick.
//
// Ports:
//   sys_clk : the single clock
//   rst_n   : asynchronous active-low reset
//   bus     : player_input_conditioner_if.slave
//             (raw_buttons, frame_tick -> player_buttons, buttons_valid,
//              debounced)
//
// Parameters:
//   INPUT_DEPTH     : button vector width
//   DEBOUNCE_CYCLES : stable cycles required to accept a level change (>= 2)
//   CNT_WIDTH       : debounce counter width, 2^CNT_WIDTH > DEBOUNCE_CYCLES-1
//   FACES_LEFT      : 1 swaps forward/backward (player on the right side)
//   K/B/G/WB/WF_BUTTON : bit indices within the button vector
// ---------------------------------------------------------------------------
module player_input_conditioner #(
    parameter int INPUT_DEPTH     = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WIDTH       = 18,
    parameter bit FACES_LEFT      = 1'b0,
    parameter int K_BUTTON        = 0,
    parameter int B_BUTTON        = 1,
    parameter int G_BUTTON        = 2,
    parameter int WB_BUTTON       = 3,
    parameter int WF_BUTTON       = 4
) (
    input  logic                           sys_clk,
    input  logic                           rst_n,
    player_input_conditioner_if.slave      bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Only the action buttons are latched; walk bits are level-sampled.
    localparam logic [INPUT_DEPTH-1:0] STICKY_MASK =
        INPUT_DEPTH'((1 << K_BUTTON) | (1 << B_BUTTON) | (1 << G_BUTTON));

    logic [INPUT_DEPTH-1:0] sync_q1;
    logic [INPUT_DEPTH-1:0] sync_q2;
    logic [INPUT_DEPTH-1:0] s;
    logic [INPUT_DEPTH-1:0] stab;
    logic [CNT_WIDTH-1:0]   cnt [INPUT_DEPTH];
    logic [INPUT_DEPTH-1:0] seen;
    logic [INPUT_DEPTH-1:0] walk;
    logic [INPUT_DEPTH-1:0] player_buttons_q;
    logic                   buttons_valid_q;
    logic                   fwd;
    logic                   bwd;

    // Synchronizer resets to all-ones: the released level of active-low keys.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= bus.raw_buttons;
            sync_q2 <= sync_q1;
        end
    end

    assign s = ~sync_q2;

    // A level is accepted only after DEBOUNCE_CYCLES consecutive cycles
    // differing from the current stable value; any return resets the count.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            stab <= '0;
            for (int i = 0; i < INPUT_DEPTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < INPUT_DEPTH; i++) begin
                if (s[i] == stab[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stab[i] <= s[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Physical right/left to forward/backward; pressing both cancels the walk.
    always_comb begin
        walk = '0;
        fwd  = FACES_LEFT ? stab[WB_BUTTON] : stab[WF_BUTTON];
        bwd  = FACES_LEFT ? stab[WF_BUTTON] : stab[WB_BUTTON];
        if (!(fwd && bwd)) begin
            walk[WF_BUTTON] = fwd;
            walk[WB_BUTTON] = bwd;
        end
    end

    // The tick clears the latch even if a press is present this cycle; that
    // press is already in the captured vector through the stab term.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            seen             <= '0;
            player_buttons_q <= '0;
            buttons_valid_q  <= 1'b0;
        end else if (bus.frame_tick) begin
            seen             <= '0;
            player_buttons_q <= ((seen | stab) & STICKY_MASK) | walk;
            buttons_valid_q  <= 1'b1;
        end else begin
            seen            <= seen | (stab & STICKY_MASK);
            buttons_valid_q <= 1'b0;
        end
    end

    assign bus.player_buttons = player_buttons_q;
    assign bus.buttons_valid  = buttons_valid_q;
    assign bus.debounced      = stab;

endmodule
